dp_hdr_seg_writer: RTL and testbench

- Transmit end of the dp_segs interface. Writes the first SEG_NUM beats of each data packet into the header segment store as indexed 256b segments (wea/addra), then pulses valid once the header image is complete.
- Sits on the data-packet AXIS path ahead of the lookup/extraction stage. The full packet continues unchanged through a registered AXIS output.
- Short packets are zero-filled to SEG_NUM segments, so downstream extraction always sees a defined header image.

---
 rtl/dp_hdr_seg_writer.sv | 150 +++++++++++++++
 tb/tb_dp_hdr_seg_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_hdr_seg_writer.sv
// rtl/dp_hdr_seg_writer.sv - header segment writer with registered AXIS pass-through
//
// Copies the first SEG_NUM beats of every packet into the header segment store
// (o_dp_segs_wea/addra/tdata). Bytes with tkeep=0 are written as zero. Short
// packets are zero-filled up to SEG_NUM segments. o_dp_segs_valid pulses with
// the final segment write. The packet itself leaves unchanged through a
// one-stage register.
//
// Ports:
//   axis_clk, areset      clock, synchronous active-high reset
//   s_axis_*              packet input (tdata/tuser/tkeep/tvalid/tlast/tready)
//   m_axis_*              registered packet output
//   o_dp_segs_tdata       segment write data (tkeep-masked or zero fill)
//   o_dp_segs_wea         segment write enable, one cycle per segment
//   o_dp_segs_addra       segment index
//   o_dp_segs_valid       header image complete, single-cycle pulse
//   o_hdr_beats           number of real beats in the header, 1..SEG_NUM
module dp_hdr_seg_writer #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int SEG_ADDR           = 3,
    parameter int SEG_NUM            = 4
) (
    input  logic                              axis_clk,
    input  logic                              areset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]      o_dp_segs_tdata,
    output logic                              o_dp_segs_wea,
    output logic [SEG_ADDR-1:0]               o_dp_segs_addra,
    output logic                              o_dp_segs_valid,
    output logic [SEG_ADDR:0]                 o_hdr_beats
);

    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam logic [SEG_ADDR:0] LAST_IDX = (SEG_ADDR + 1)'(SEG_NUM - 1);
    localparam logic [SEG_ADDR:0] SEG_CNT  = (SEG_ADDR + 1)'(SEG_NUM);
    localparam logic [SEG_ADDR:0] CNT_ONE  = (SEG_ADDR + 1)'(1);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t                         state_q;
    logic [SEG_ADDR:0]              beat_cnt_q;
    logic                           accept;
    logic [C_AXIS_DATA_WIDTH-1:0]   seg_masked;

    // FILL owns the segment write port, so input is held off while it runs.
    assign s_axis_tready = (m_axis_tready || !m_axis_tvalid) && (state_q != FILL);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        seg_masked = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            seg_masked[i*8 +: 8] = s_axis_tkeep[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
        end
    end

    // Pass-through register stage.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Segment writer FSM; data/addra hold their last value between writes.
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state_q         <= HDR;
            beat_cnt_q      <= '0;
            o_dp_segs_tdata <= '0;
            o_dp_segs_wea   <= 1'b0;
            o_dp_segs_addra <= '0;
            o_dp_segs_valid <= 1'b0;
            o_hdr_beats     <= '0;
        end else begin
            o_dp_segs_wea   <= 1'b0;
            o_dp_segs_valid <= 1'b0;
            case (state_q)
                HDR: begin
                    if (accept) begin
                        o_dp_segs_wea   <= 1'b1;
                        o_dp_segs_addra <= beat_cnt_q[SEG_ADDR-1:0];
                        o_dp_segs_tdata <= seg_masked;
                        if (beat_cnt_q == LAST_IDX) begin
                            o_dp_segs_valid <= 1'b1;
                            o_hdr_beats     <= SEG_CNT;
                            beat_cnt_q      <= '0;
                            state_q         <= s_axis_tlast ? HDR : BODY;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_ONE;
                            if (s_axis_tlast) begin
                                o_hdr_beats <= beat_cnt_q + CNT_ONE;
                                state_q     <= FILL;
                            end
                        end
                    end
                end
                FILL: begin
                    o_dp_segs_wea   <= 1'b1;
                    o_dp_segs_addra <= beat_cnt_q[SEG_ADDR-1:0];
                    o_dp_segs_tdata <= '0;
                    if (beat_cnt_q == LAST_IDX) begin
                        o_dp_segs_valid <= 1'b1;
                        beat_cnt_q      <= '0;
                        state_q         <= HDR;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + CNT_ONE;
                    end
                end
                BODY: begin
                    if (accept && s_axis_tlast) begin
                        beat_cnt_q <= '0;
                        state_q    <= HDR;
                    end
                end
                default: begin
                    beat_cnt_q <= '0;
                    state_q    <= HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_hdr_seg_writer.sv
// tb/tb_dp_hdr_seg_writer.sv - directed self-checking bench for dp_hdr_seg_writer
module tb_dp_hdr_seg_writer;

    logic          axis_clk = 1'b0;
    logic          areset   = 1'b1;
    logic [255:0]  s_axis_tdata  = '0;
    logic [127:0]  s_axis_tuser  = '0;
    logic [31:0]   s_axis_tkeep  = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast  = 1'b0;
    logic          s_axis_tready;
    logic [255:0]  m_axis_tdata;
    logic [127:0]  m_axis_tuser;
    logic [31:0]   m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [255:0]  o_dp_segs_tdata;
    logic          o_dp_segs_wea;
    logic [2:0]    o_dp_segs_addra;
    logic          o_dp_segs_valid;
    logic [3:0]    o_hdr_beats;

    dp_hdr_seg_writer dut (
        .axis_clk        (axis_clk),
        .areset          (areset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .o_dp_segs_tdata (o_dp_segs_tdata),
        .o_dp_segs_wea   (o_dp_segs_wea),
        .o_dp_segs_addra (o_dp_segs_addra),
        .o_dp_segs_valid (o_dp_segs_valid),
        .o_hdr_beats     (o_hdr_beats)
    );

    always #5 axis_clk = ~axis_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit toggle_en = 1'b0;

    logic [255:0] wr_data_q[$];
    int           wr_addr_q[$];
    int           wr_cyc_q[$];
    int           acc_cyc_q[$];
    int           val_cyc_q[$];
    int           val_hb_q[$];
    logic [255:0] out_data_q[$];
    int           out_last_q[$];
    int           nrdy;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge axis_clk) cyc <= cyc + 1;

    always @(posedge axis_clk) begin
        #1;
        if (toggle_en) m_axis_tready = ~m_axis_tready;
    end

    // Event log sampled mid-cycle.
    always @(negedge axis_clk) begin
        if (!areset) begin
            if (o_dp_segs_wea) begin
                wr_data_q.push_back(o_dp_segs_tdata);
                wr_addr_q.push_back(int'(o_dp_segs_addra));
                wr_cyc_q.push_back(cyc);
            end
            if (o_dp_segs_valid) begin
                val_cyc_q.push_back(cyc);
                val_hb_q.push_back(int'(o_hdr_beats));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_data_q.push_back(m_axis_tdata);
                out_last_q.push_back(int'(m_axis_tlast));
            end
            if (s_axis_tvalid && s_axis_tready) acc_cyc_q.push_back(cyc);
            if (!s_axis_tready) nrdy++;
        end
    end

    function automatic logic [255:0] mk(input int t, input int i);
        logic [15:0] a, b;
        a = t[15:0];
        b = i[15:0];
        return {8{a, b}};
    endfunction

    task automatic clear_logs();
        wr_data_q.delete(); wr_addr_q.delete(); wr_cyc_q.delete(); acc_cyc_q.delete();
        val_cyc_q.delete(); val_hb_q.delete(); out_data_q.delete(); out_last_q.delete();
        nrdy = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        bit ok;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = {4{d[31:0]}};
        s_axis_tvalid = 1'b1;
        for (int w = 0; w < 100; w++) begin
            @(negedge axis_clk);
            if (s_axis_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge axis_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int t, input int n);
        for (int i = 0; i < n; i++) send_beat(mk(t, i), 32'hFFFF_FFFF, (i == n - 1));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_segs_tdata"}, o_dp_segs_tdata, 0);
        check({tag, "_wea"},        o_dp_segs_wea, 0);
        check({tag, "_addra"},      o_dp_segs_addra, 0);
        check({tag, "_valid"},      o_dp_segs_valid, 0);
        check({tag, "_hdr_beats"},  o_hdr_beats, 0);
        check({tag, "_m_tvalid"},   m_axis_tvalid, 0);
        check({tag, "_m_tdata"},    m_axis_tdata, 0);
        check({tag, "_m_tlast"},    m_axis_tlast, 0);
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_wr_count"}, wr_addr_q.size(), n);
        for (int i = 0; i < wr_addr_q.size() && i < n; i++)
            check({tag, "_wr_addr"}, wr_addr_q[i], i % 4);
    endtask

    initial begin
        nrdy = 0;
        idle(3);
        @(negedge axis_clk);
        check_outputs_zero("reset");
        check("reset_s_tready", s_axis_tready, 1);
        @(posedge axis_clk); #1;
        areset = 1'b0;
        idle(2);

        // 1: 6-beat packet
        clear_logs();
        send_pkt(1, 6);
        idle(6);
        check_writes("t1", 4);
        for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
            check("t1_wr_data", wr_data_q[i], mk(1, i));
            if (i < acc_cyc_q.size()) check("t1_wr_latency", wr_cyc_q[i], acc_cyc_q[i] + 1);
        end
        check("t1_valid_count", val_cyc_q.size(), 1);
        if (val_cyc_q.size() == 1 && wr_cyc_q.size() == 4) begin
            check("t1_valid_cyc", val_cyc_q[0], wr_cyc_q[3]);
            check("t1_hdr_beats", val_hb_q[0], 4);
        end
        check("t1_out_count", out_data_q.size(), 6);
        for (int i = 0; i < out_data_q.size() && i < 6; i++) begin
            check("t1_out_data", out_data_q[i], mk(1, i));
            check("t1_out_last", out_last_q[i], (i == 5));
        end

        // 2: 2-beat packet, zero fill
        clear_logs();
        send_pkt(2, 2);
        idle(6);
        check_writes("t2", 4);
        if (wr_data_q.size() == 4) begin
            check("t2_wr0", wr_data_q[0], mk(2, 0));
            check("t2_wr1", wr_data_q[1], mk(2, 1));
            check("t2_wr2_fill", wr_data_q[2], 0);
            check("t2_wr3_fill", wr_data_q[3], 0);
            check("t2_fill_gap", wr_cyc_q[3] - wr_cyc_q[1], 2);
        end
        check("t2_not_ready_cycles", nrdy, 2);
        check("t2_valid_count", val_cyc_q.size(), 1);
        if (val_cyc_q.size() == 1 && wr_cyc_q.size() == 4) begin
            check("t2_valid_cyc", val_cyc_q[0], wr_cyc_q[3]);
            check("t2_hdr_beats", val_hb_q[0], 2);
        end

        // 3: tkeep masking on beat 1 only affects the segment copy
        clear_logs();
        send_beat(mk(3, 0), 32'hFFFF_FFFF, 1'b0);
        send_beat(mk(3, 1), 32'h0000_FFFF, 1'b0);
        send_beat(mk(3, 2), 32'hFFFF_FFFF, 1'b0);
        send_beat(mk(3, 3), 32'hFFFF_FFFF, 1'b1);
        idle(4);
        check_writes("t3", 4);
        if (wr_data_q.size() == 4) check("t3_masked", wr_data_q[1], {128'h0, mk(3, 1)} & {128'h0, {128{1'b1}}});
        if (out_data_q.size() == 4) check("t3_out_unmasked", out_data_q[1], mk(3, 1));

        // 4: m_axis_tready toggling
        clear_logs();
        toggle_en = 1'b1;
        send_pkt(4, 4);
        idle(6);
        toggle_en = 1'b0;
        m_axis_tready = 1'b1;
        idle(3);
        check("t4_out_count", out_data_q.size(), 4);
        for (int i = 0; i < out_data_q.size() && i < 4; i++) begin
            check("t4_out_data", out_data_q[i], mk(4, i));
            check("t4_out_last", out_last_q[i], (i == 3));
        end
        check_writes("t4", 4);
        for (int i = 0; i < wr_cyc_q.size() && i < acc_cyc_q.size(); i++)
            check("t4_wr_on_accept", wr_cyc_q[i], acc_cyc_q[i] + 1);
        check("t4_valid_count", val_cyc_q.size(), 1);

        // 5: reset mid-packet, then a fresh packet
        send_beat(mk(5, 0), 32'hFFFF_FFFF, 1'b0);
        send_beat(mk(5, 1), 32'hFFFF_FFFF, 1'b0);
        areset = 1'b1;
        @(posedge axis_clk); #1;
        @(negedge axis_clk);
        check_outputs_zero("t5_reset");
        @(posedge axis_clk); #1;
        areset = 1'b0;
        clear_logs();
        send_pkt(6, 4);
        idle(4);
        check_writes("t5", 4);
        check("t5_valid_count", val_cyc_q.size(), 1);
        if (wr_data_q.size() == 4) check("t5_wr0", wr_data_q[0], mk(6, 0));

        // 6: back-to-back 4-beat packets
        clear_logs();
        send_pkt(7, 4);
        send_pkt(8, 4);
        idle(4);
        check_writes("t6", 8);
        if (wr_cyc_q.size() == 8) check("t6_no_stall", wr_cyc_q[7] - wr_cyc_q[0], 7);
        check("t6_valid_count", val_cyc_q.size(), 2);
        if (val_cyc_q.size() == 2) check("t6_valid_gap", val_cyc_q[1] - val_cyc_q[0], 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
